mips_cpu_fetch_decode: RTL

//  Instruction fetch/decode front end: owns the PC, fetches words over the Avalon read port and splits them into fields.

---
 rtl/mips_cpu_fetch_decode.sv | 84 ++++++++
 1 files changed

// File: rtl/mips_cpu_fetch_decode.sv
// mips_cpu_fetch_decode: MIPS fetch/decode front end with Avalon read port, branch-delay slot and halt-on-PC==0
module mips_cpu_fetch_decode #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter bit          BYTE_SWAP    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] address,
   output logic        read,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc_out,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [4:0]  rd_addr,
   output logic [4:0]  shamt,
   output logic [15:0] immediate,
   output logic [25:0] target,
   input  logic        pc_load,
   input  logic [31:0] pc_load_value,
   output logic        active
);
   localparam logic [1:0] FETCH  = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;
   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] fetched;
   logic [31:0] next_pc;
   logic [31:0] pending_pc;
   logic        pending;
   // Bus side, fetched word ordering and the pc that follows the held instruction
   always_comb begin
      fetched = BYTE_SWAP ? {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]} : readdata;
      next_pc = pending ? pending_pc : pc + 32'd4;
      read = state == FETCH && !reset;
      address = pc;
      pc_out = pc;
      instr_valid = state == HOLD;
   end
   // Field split of the held instruction
   always_comb begin
      opcode = ir[31:26];
      rs_addr = ir[25:21];
      rt_addr = ir[20:16];
      rd_addr = ir[15:11];
      shamt = ir[10:6];
      funct = ir[5:0];
      immediate = ir[15:0];
      target = ir[25:0];
   end
   // Fetch/hold sequencing; a taken branch is parked until its delay slot has been handed off
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc <= RESET_VECTOR;
         ir <= '0;
         pending <= 1'b0;
         pending_pc <= '0;
         active <= 1'b1;
      end else if (state == FETCH) begin
         if (!waitrequest) begin
            ir <= fetched;
            state <= HOLD;
         end
      end else if (state == HOLD && instr_ready) begin
         pending <= !pending && pc_load;
         if (!pending && pc_load)
            pending_pc <= {pc_load_value[31:2], 2'b00};
         if (next_pc == '0) begin
            state <= HALTED;
            active <= 1'b0;
         end else begin
            pc <= next_pc;
            state <= FETCH;
         end
      end
   end
endmodule
